// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation datapath and its controller.
package modexp_pkg;

   localparam int unsigned WidthDefault = 8;

   typedef enum logic [1:0] {
      StEmpty,
      StLoaded,
      StBusy
   } dp_state_e;

   // Controller states, kept here so the FSM and the datapath agree on one encoding.
   typedef enum logic [2:0] {
      CtlWaiting,
      CtlInitialize,
      CtlMultiply,
      CtlModulo,
      CtlDone
   } ctl_state_e;

endpackage

// File: rtl/modexp_reducer.sv
// Single-cycle combinational remainder of a 2*WIDTH dividend by a WIDTH divisor.
module modexp_reducer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic [WIDTH-1:0]   remainder
);

   localparam int unsigned PW = 2 * WIDTH;

   always_comb begin
      remainder = '0;
      // A zero divisor yields zero so the datapath never sees an undefined remainder.
      if (divisor != '0) begin
         remainder = WIDTH'(dividend % PW'(divisor));
      end
   end

endmodule

// File: rtl/modexp_datapath.sv
// Operand capture, multiply/reduce steps and result presentation for base^exp mod m.
module modexp_datapath
   import modexp_pkg::*;
#(
   parameter int unsigned WIDTH = WidthDefault
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] base_in,
   input  logic [WIDTH-1:0] exp_in,
   input  logic [WIDTH-1:0] mod_in,
   input  logic             initialize,
   input  logic             en_multiply,
   input  logic             en_modulo,
   input  logic             done,
   output logic             input_data_ready,
   output logic             is_multiplication_done,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             mod_err,
   output logic             proto_err
);

   localparam int unsigned PW = 2 * WIDTH;

   dp_state_e        state_q, state_d;
   logic [WIDTH-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d;
   logic [WIDTH-1:0] acc_q, acc_d, count_q, count_d, result_q, result_d;
   logic [PW-1:0]    product_q, product_d;
   logic             rdy_q, rdy_d, busy_q, busy_d, rv_q, rv_d;
   logic             mod_err_q, mod_err_d, proto_q, proto_d;
   logic [WIDTH-1:0] remainder;

   modexp_reducer #(
      .WIDTH (WIDTH)
   ) u_reducer (
      .dividend  (product_q),
      .divisor   (mod_q),
      .remainder (remainder)
   );

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      exp_d     = exp_q;
      mod_d     = mod_q;
      acc_d     = acc_q;
      count_d   = count_q;
      product_d = product_q;
      result_d  = result_q;
      rdy_d     = rdy_q;
      busy_d    = busy_q;
      rv_d      = rv_q;
      mod_err_d = mod_err_q;
      proto_d   = proto_q;

      if ((en_multiply && en_modulo) || ((en_multiply || en_modulo) && state_q != StBusy)) begin
         proto_d = 1'b1;
      end

      if (state_q == StBusy) begin
         // Reduction wins over a simultaneous multiply; the multiply is dropped.
         if (en_modulo) begin
            acc_d = mod_err_q ? '0 : remainder;
         end else if (en_multiply && count_q != '0) begin
            product_d = PW'(acc_q) * PW'(base_q);
            count_d   = count_q - 1'b1;
         end
      end

      if (initialize && state_q != StEmpty) begin
         // Restart uses the operands already held; a same-cycle load is ignored.
         state_d   = StBusy;
         acc_d     = (mod_q > WIDTH'(1)) ? WIDTH'(1) : '0;
         count_d   = exp_q;
         product_d = '0;
         mod_err_d = (mod_q == '0);
         rdy_d     = 1'b0;
         busy_d    = 1'b1;
         rv_d      = 1'b0;
      end else if (done && state_q == StBusy) begin
         state_d  = StLoaded;
         result_d = acc_q;
         rv_d     = 1'b1;
         busy_d   = 1'b0;
         rdy_d    = 1'b1;
      end else if (load && state_q != StBusy) begin
         state_d = StLoaded;
         base_d  = base_in;
         exp_d   = exp_in;
         mod_d   = mod_in;
         rdy_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StEmpty;
         base_q    <= '0;
         exp_q     <= '0;
         mod_q     <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         product_q <= '0;
         result_q  <= '0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
         rv_q      <= 1'b0;
         mod_err_q <= 1'b0;
         proto_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         exp_q     <= exp_d;
         mod_q     <= mod_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         product_q <= product_d;
         result_q  <= result_d;
         rdy_q     <= rdy_d;
         busy_q    <= busy_d;
         rv_q      <= rv_d;
         mod_err_q <= mod_err_d;
         proto_q   <= proto_d;
      end
   end

   assign input_data_ready       = rdy_q;
   assign busy                   = busy_q;
   assign is_multiplication_done = busy_q && (count_q == '0);
   assign result                 = result_q;
   assign result_valid           = rv_q;
   assign mod_err                = mod_err_q;
   assign proto_err              = proto_q;

endmodule

// File: tb/tb_modexp_datapath.sv
// Randomized and directed checks of modexp_datapath against a plain-arithmetic power-mod model.
module tb_modexp_datapath;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0, initialize = 1'b0, en_multiply = 1'b0, en_modulo = 1'b0;
   logic         done = 1'b0;
   logic [W-1:0] base_in = '0, exp_in = '0, mod_in = '0;
   logic         input_data_ready, is_multiplication_done, busy, result_valid;
   logic         mod_err, proto_err;
   logic [W-1:0] result;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   modexp_datapath #(
      .WIDTH (W)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .load                   (load),
      .base_in                (base_in),
      .exp_in                 (exp_in),
      .mod_in                 (mod_in),
      .initialize             (initialize),
      .en_multiply            (en_multiply),
      .en_modulo              (en_modulo),
      .done                   (done),
      .input_data_ready       (input_data_ready),
      .is_multiplication_done (is_multiplication_done),
      .busy                   (busy),
      .result                 (result),
      .result_valid           (result_valid),
      .mod_err                (mod_err),
      .proto_err              (proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected answer straight from the definition of base^exp mod m.
   function automatic int unsigned model_pow(input int unsigned b, input int unsigned e,
                                             input int unsigned m);
      longint unsigned r;
      if (m <= 1) return 0;
      r = 1;
      for (int i = 0; i < int'(e); i++) r = (r * b) % m;
      return int'(r);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int unsigned b, input int unsigned e, input int unsigned m);
      base_in = W'(b);
      exp_in  = W'(e);
      mod_in  = W'(m);
      load    = 1'b1;
      step();
      load = 1'b0;
      check("ready_after_load", input_data_ready, 1);
   endtask

   // Acts as the controller; inj_both drives both enables on the first step,
   // junk drives a load with other operands while busy.
   task automatic run_ctl(input bit inj_both, input bit junk, output int unsigned pairs);
      initialize = 1'b1;
      step();
      initialize = 1'b0;
      check("busy_after_init", busy, 1);
      check("ready_low_in_busy", input_data_ready, 0);
      check("rv_low_in_busy", result_valid, 0);
      if (inj_both) begin
         en_multiply = 1'b1;
         en_modulo   = 1'b1;
         step();
         en_multiply = 1'b0;
         en_modulo   = 1'b0;
      end
      pairs = 0;
      while (!is_multiplication_done && pairs < 300) begin
         en_multiply = 1'b1;
         if (junk && pairs == 0) begin
            load    = 1'b1;
            base_in = W'($urandom);
            exp_in  = W'($urandom);
            mod_in  = W'($urandom);
         end
         step();
         en_multiply = 1'b0;
         load        = 1'b0;
         en_modulo   = 1'b1;
         step();
         en_modulo = 1'b0;
         pairs++;
      end
      check("rv_low_before_done", result_valid, 0);
      done = 1'b1;
      step();
      done = 1'b0;
      check("rv_after_done", result_valid, 1);
      check("busy_low_after_done", busy, 0);
      check("ready_after_done", input_data_ready, 1);
   endtask

   initial begin
      int unsigned pairs, b, e, m;
      step();
      check("rst_ready", input_data_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_result", result, 0);
      check("rst_rv", result_valid, 0);
      check("rst_mod_err", mod_err, 0);
      check("rst_proto", proto_err, 0);
      rst = 1'b0;
      step();

      do_load(3, 4, 7);
      run_ctl(1'b0, 1'b0, pairs);
      check("pairs_3_4_7", pairs, 4);
      check("res_3_4_7", result, 4);

      do_load(200, 2, 251);
      run_ctl(1'b0, 1'b0, pairs);
      check("res_200_2_251", result, 91);

      do_load(9, 0, 5);
      run_ctl(1'b0, 1'b0, pairs);
      check("pairs_exp0", pairs, 0);
      check("res_exp0_m5", result, 1);
      do_load(9, 0, 1);
      run_ctl(1'b0, 1'b0, pairs);
      check("res_exp0_m1", result, 0);

      do_load(5, 3, 0);
      run_ctl(1'b0, 1'b0, pairs);
      check("mod_err_set", mod_err, 1);
      check("res_mod0", result, 0);
      do_load(3, 4, 7);
      run_ctl(1'b0, 1'b0, pairs);
      check("mod_err_clr", mod_err, 0);
      check("res_after_mod0", result, 4);

      // Reset during the second multiply step aborts the run.
      do_load(3, 4, 7);
      initialize = 1'b1;
      step();
      initialize = 1'b0;
      en_multiply = 1'b1;
      step();
      en_multiply = 1'b0;
      en_modulo = 1'b1;
      step();
      en_modulo = 1'b0;
      en_multiply = 1'b1;
      #2 rst = 1'b1;
      #1;
      en_multiply = 1'b0;
      check("rstmid_busy", busy, 0);
      check("rstmid_ready", input_data_ready, 0);
      check("rstmid_result", result, 0);
      check("rstmid_rv", result_valid, 0);
      check("rstmid_imd", is_multiplication_done, 0);
      base_in = 8'd2; exp_in = 8'd2; mod_in = 8'd9;
      load = 1'b1;
      step();
      load = 1'b0;
      check("load_in_rst_ignored", input_data_ready, 0);
      rst = 1'b0;
      step();
      check("ready_still_low", input_data_ready, 0);
      do_load(3, 4, 7);
      run_ctl(1'b0, 1'b0, pairs);
      check("res_after_rst", result, 4);

      // Enable while LOADED, then both enables while busy.
      check("proto_clear", proto_err, 0);
      do_load(3, 4, 7);
      en_multiply = 1'b1;
      step();
      en_multiply = 1'b0;
      check("proto_loaded", proto_err, 1);
      run_ctl(1'b1, 1'b0, pairs);
      check("proto_pairs", pairs, 4);
      check("proto_res", result, 0);
      check("proto_sticky", proto_err, 1);

      for (int i = 0; i < 25; i++) begin
         b = $urandom_range(255);
         e = $urandom_range(12);
         case ($urandom_range(5))
            0:       m = 0;
            1:       m = 1;
            default: m = $urandom_range(255);
         endcase
         do_load(b, e, m);
         run_ctl(1'b0, e > 0, pairs);
         check("rand_pairs", pairs, e);
         check("rand_res", result, model_pow(b, e, m));
         check("rand_mod_err", mod_err, (m == 0) ? 1 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
